// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive stimulus engine: walks every DUT input vector (count or LFSR),
// streams (vector, response) records and compacts responses into a MISR.
module exhaustive_vector_sweeper #(
   parameter int               N_IN   = 5,
   parameter int               N_OUT  = 1,
   parameter int               SETTLE = 1,
   parameter int               SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
   input  logic              CK,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic [N_IN-1:0]   seed,
   input  logic [N_OUT-1:0]  dut_resp,
   input  logic              cap_ready,
   output logic [N_IN-1:0]   vec,
   output logic              busy,
   output logic              cap_valid,
   output logic [N_IN-1:0]   cap_vec,
   output logic [N_OUT-1:0]  cap_resp,
   output logic [N_IN-1:0]   cap_idx,
   output logic              done,
   output logic [SIG_W-1:0]  signature
);

   localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);
   localparam logic [N_IN-1:0]  ALL_ONES = '1;

   // Feedback tap masks (bit positions XORed into bit 0), maximal length.
   function automatic logic [15:0] tap_mask(input int n);
      logic [15:0] m;
      case (n)
         2:       m = 16'h0003;
         3:       m = 16'h0006;
         4:       m = 16'h000C;
         5:       m = 16'h0012;
         6:       m = 16'h0030;
         7:       m = 16'h0060;
         8:       m = 16'h00B8;
         9:       m = 16'h0110;
         10:      m = 16'h0240;
         11:      m = 16'h0500;
         12:      m = 16'h0829;
         13:      m = 16'h100D;
         14:      m = 16'h2015;
         15:      m = 16'h6000;
         16:      m = 16'hD008;
         default: m = 16'h0003;
      endcase
      return m;
   endfunction

   localparam logic [15:0]     TAPS    = tap_mask(N_IN);
   localparam logic [N_IN-1:0] TAP_SEL = TAPS[N_IN-1:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t            state;
   logic              lfsr_mode;
   logic [CNT_W-1:0]  cnt;
   logic [N_IN-1:0]   first_vec;
   logic [N_IN-1:0]   next_vec;
   logic [N_IN-1:0]   last_idx;
   logic [SIG_W-1:0]  sig_next;

   always_comb begin
      first_vec = '0;
      if (mode)
         first_vec = (seed == '0) ? N_IN'(1) : seed;
   end

   always_comb begin
      next_vec = vec + N_IN'(1);
      last_idx = ALL_ONES;
      if (lfsr_mode) begin
         next_vec = {vec[N_IN-2:0], ^(vec & TAP_SEL)};
         last_idx = ALL_ONES - N_IN'(1);
      end
   end

   always_comb begin
      sig_next = {signature[SIG_W-2:0], 1'b0};
      if (signature[SIG_W-1])
         sig_next = sig_next ^ POLY;
      sig_next = sig_next ^ SIG_W'(cap_resp);
   end

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         lfsr_mode <= 1'b0;
         cnt       <= '0;
         vec       <= '0;
         busy      <= 1'b0;
         cap_valid <= 1'b0;
         cap_vec   <= '0;
         cap_resp  <= '0;
         cap_idx   <= '0;
         done      <= 1'b0;
         signature <= '0;
      end else if (abort) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         cap_valid <= 1'b0;
         done      <= 1'b0;
         signature <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  vec       <= first_vec;
                  cap_idx   <= '0;
                  signature <= '0;
                  cnt       <= CNT_INIT;
                  lfsr_mode <= mode;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  cap_resp  <= dut_resp;
                  cap_vec   <= vec;
                  cap_valid <= 1'b1;
                  state     <= S_CAPTURE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_CAPTURE: begin
               if (cap_ready) begin
                  signature <= sig_next;
                  cap_valid <= 1'b0;
                  if (cap_idx == last_idx) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     vec     <= next_vec;
                     cap_idx <= cap_idx + N_IN'(1);
                     cnt     <= CNT_INIT;
                     state   <= S_SETTLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Randomized bench for exhaustive_vector_sweeper against a list-based
// model of the vector order, response table and MISR.
module tb_exhaustive_vector_sweeper;

   localparam int N = 5;

   logic          CK = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic          mode;
   logic [N-1:0]  seed;
   logic [0:0]    dut_resp;
   logic          cap_ready;
   logic [N-1:0]  vec;
   logic          busy;
   logic          cap_valid;
   logic [N-1:0]  cap_vec;
   logic [0:0]    cap_resp;
   logic [N-1:0]  cap_idx;
   logic          done;
   logic [15:0]   signature;

   int n_cmp = 0;
   int n_bad = 0;

   logic         rtab [32];
   logic [N-1:0] got_vecs [$];
   logic [N-1:0] lfsr_run1 [$];
   logic [15:0]  s_a, s_b, s_c;

   always #5 CK = ~CK;

   // Combinational stand-in for the device under test.
   always_comb dut_resp = rtab[vec];

   exhaustive_vector_sweeper #(
      .N_IN(N), .N_OUT(1), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)
   ) dut (
      .CK(CK), .reset(reset), .start(start), .abort(abort),
      .mode(mode), .seed(seed), .dut_resp(dut_resp),
      .cap_ready(cap_ready), .vec(vec), .busy(busy),
      .cap_valid(cap_valid), .cap_vec(cap_vec),
      .cap_resp(cap_resp), .cap_idx(cap_idx), .done(done),
      .signature(signature)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   function automatic logic [15:0] misr(input logic [15:0] s,
                                        input logic r);
      logic [16:0] t;
      t = {s, 1'b0};
      if (s[15]) t[15:0] = t[15:0] ^ 16'h1021;
      return t[15:0] ^ {15'd0, r};
   endfunction

   task automatic sweep(input bit m, input logic [N-1:0] sd,
                        input int stall_rec, input int rdy_pct,
                        input bit timing, input bit ones,
                        output logic [15:0] sig_out);
      logic [N-1:0] e [$];
      logic [N-1:0] v;
      logic [15:0]  ms;
      bit           seen [32];
      int           k, cyc, first_v, last_hs, stall;
      bit           rdy;
      e.delete();
      got_vecs.delete();
      if (!m) begin
         for (int i = 0; i < 32; i++) e.push_back(N'(i));
      end else begin
         v = (sd == 0) ? N'(1) : sd;
         for (int i = 0; i < 31; i++) begin
            e.push_back(v);
            v = {v[3:0], v[4] ^ v[1]};
         end
      end
      for (int i = 0; i < 32; i++) seen[i] = 1'b0;
      ms = 0; k = 0; cyc = 0; first_v = -1; last_hs = -1; stall = 0;
      mode = m; seed = sd; start = 1'b1; cap_ready = 1'b0;
      tick();
      start = 1'b0;
      mode = 1'($urandom);
      seed = N'($urandom);
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_sig", signature, 0);
      while (!done && cyc < 3000) begin
         if (cap_valid && first_v < 0) first_v = cyc;
         if (cap_valid && k == stall_rec && stall < 7) begin
            rdy = 1'b0;
            stall++;
            chk("stall_capvec", cap_vec, e[k]);
            chk("stall_capidx", cap_idx, k);
            chk("stall_resp", cap_resp, rtab[e[k]]);
            chk("stall_vec", vec, e[k]);
            chk("stall_sig", signature, ms);
         end else begin
            rdy = (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
         end
         cap_ready = rdy;
         if (cap_valid && rdy) begin
            if (k < e.size()) begin
               chk("rec_vec", cap_vec, e[k]);
               chk("rec_idx", cap_idx, k);
               chk("rec_resp", cap_resp, rtab[e[k]]);
               chk("rec_sig", signature, ms);
               ms = misr(ms, rtab[e[k]]);
            end else begin
               chk("extra_rec", k, e.size());
            end
            if (ones && k == 2) chk("sig_after2", signature, 16'h0003);
            if (ones && k == 3) chk("sig_after3", signature, 16'h0007);
            if (timing && k > 0) chk("spacing", cyc - last_hs, 3);
            chk("uniq_vec", seen[cap_vec], 0);
            seen[cap_vec] = 1'b1;
            got_vecs.push_back(cap_vec);
            last_hs = cyc;
            k++;
         end
         tick();
         cyc++;
      end
      cap_ready = 1'b0;
      chk("sweep_done", done, 1);
      chk("rec_count", k, e.size());
      chk("final_sig", signature, ms);
      chk("busy_after", busy, 0);
      if (timing) begin
         chk("first_valid", first_v, 2);
         chk("done_latency", cyc - last_hs, 1);
      end
      if (stall_rec >= 0) chk("stall_len", stall, 7);
      if (m) chk("lfsr_no_zero", seen[0], 0);
      sig_out = signature;
   endtask

   initial begin : main
      bit found;
      reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
      seed = '0; cap_ready = 1'b0;
      for (int i = 0; i < 32; i++) rtab[i] = 1'($urandom);
      #3;
      chk("rst_vec", vec, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", cap_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_sig", signature, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Count sweep, always ready: order, latency and spacing.
      sweep(1'b0, '0, -1, 100, 1'b1, 1'b0, s_a);

      // LFSR sweeps with random backpressure; seed 0 behaves as seed 1.
      sweep(1'b1, N'(1), -1, 60, 1'b0, 1'b0, s_a);
      chk("lfsr_v0", got_vecs[0], 5'b00001);
      chk("lfsr_v1", got_vecs[1], 5'b00010);
      chk("lfsr_v2", got_vecs[2], 5'b00101);
      chk("lfsr_v3", got_vecs[3], 5'b01010);
      chk("lfsr_v4", got_vecs[4], 5'b10101);
      lfsr_run1 = got_vecs;
      sweep(1'b1, '0, -1, 75, 1'b0, 1'b0, s_b);
      chk("seed0_sig", s_b, s_a);
      chk("seed0_len", got_vecs.size(), lfsr_run1.size());
      for (int i = 0; i < 31 && i < got_vecs.size() &&
                      i < lfsr_run1.size(); i += 6)
         chk("seed0_seq", got_vecs[i], lfsr_run1[i]);

      // Backpressure on record 4.
      sweep(1'b0, '0, 4, 100, 1'b0, 1'b0, s_a);

      // Responses tied high: fixed early signatures, repeatable end value.
      for (int i = 0; i < 32; i++) rtab[i] = 1'b1;
      sweep(1'b0, '0, -1, 100, 1'b1, 1'b1, s_b);
      sweep(1'b0, '0, -1, 80, 1'b0, 1'b1, s_c);
      chk("repeat_sig", s_c, s_b);
      for (int i = 0; i < 32; i++) rtab[i] = 1'($urandom);

      // Abort during SETTLE of record 10.
      mode = 1'b0; cap_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (busy && !cap_valid && cap_idx == 10) found = 1'b1;
         else tick();
      end
      chk("abort_reach", found, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", cap_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_sig", signature, 0);
      chk("abort_vec", vec, 10);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      tick();
      chk("start_abort_idle", busy, 0);
      sweep(1'b0, '0, -1, 90, 1'b0, 1'b0, s_a);

      // Asynchronous reset in the middle of a capture.
      mode = 1'b0; cap_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (cap_valid && cap_idx == 3) found = 1'b1;
         else tick();
      end
      chk("reset_reach", found, 1);
      cap_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_vec", vec, 0);
      chk("arst_valid", cap_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_capvec", cap_vec, 0);
      chk("arst_capidx", cap_idx, 0);
      chk("arst_sig", signature, 0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("post_rst_valid", cap_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
